// File: rtl/aes_ctr_stream_pkg.sv
// Shared constants for the AES counter-mode stream block: widths, pipe latency,
// FSM encoding and a constant-evaluable clog2.
package aes_ctr_stream_pkg;

    localparam int AESWidth   = 128;
    localparam int AESEntropy = 128;
    localparam int AESLatency = 21;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_ctr_stream_keystream_fifo.sv
// Keystream buffer: synchronous FIFO whose head word is held in a register so
// the XOR stage sees it without a read-latency bubble.
module keystream_fifo
    import aes_ctr_stream_pkg::*;
#(
    parameter int Width = 128,
    parameter int Depth = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] din_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q;
    logic [Width-1:0] head_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = head_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            // Next head comes from storage if another entry is queued, else from the incoming word.
            if (do_pop) begin
                if (cnt_q > (AW+1)'(1)) begin
                    head_q <= mem[rd_q + AW'(1)];
                end else if (do_push) begin
                    head_q <= din_i;
                end
            end else if (do_push && empty_o) begin
                head_q <= din_i;
            end
        end
    end

endmodule

// File: rtl/aes_ctr_stream.sv
// Counter-mode front/back end around a fixed-latency AES keystream pipe.
// Optional protocol checking is enabled with the AES_CTR_CHECK_EN macro.
module aes_ctr_stream
    import aes_ctr_stream_pkg::*;
#(
    parameter int W         = 1,
    parameter int SeedWidth = AESEntropy,
    parameter int FIFODepth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [SeedWidth-1:0]    job_iv_i,
    input  logic [15:0]             job_count_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    output logic                    job_done_o,
    output logic [SeedWidth-1:0]    aes_seed_o,
    output logic                    aes_seed_valid_o,
    input  logic [W*AESWidth-1:0]   aes_keystream_i,
    input  logic                    aes_keystream_valid_i,
    input  logic [W*AESWidth-1:0]   data_in_i,
    input  logic                    data_in_valid_i,
    output logic                    data_in_ready_o,
    output logic [W*AESWidth-1:0]   data_out_o,
    output logic                    data_out_valid_o,
    input  logic                    data_out_ready_i,
    output logic                    error_o
);
    localparam int DW   = W * AESWidth;
    localparam int CntW = clog2(FIFODepth) + 1;

    logic [1:0]           state_q, state_d;
    logic [SeedWidth-1:0] seed_q, seed_d;
    logic [15:0]          rem_q, rem_d;
    logic [15:0]          out_rem_q, out_rem_d;
    logic [CntW-1:0]      outst_q, outst_d;
    logic                 zero_done_q, zero_done_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic                 dvalid_q, dvalid_d;

    logic          issue, in_hs, out_hs, last_out, ks_push;
    logic          fifo_full, fifo_empty;
    logic [DW-1:0] fifo_head;

    assign issue    = (state_q == StIssue) && (rem_q != '0) && (outst_q < CntW'(FIFODepth));
    assign data_in_ready_o = !fifo_empty && (!dvalid_q || data_out_ready_i);
    assign in_hs    = data_in_valid_i && data_in_ready_o;
    assign out_hs   = dvalid_q && data_out_ready_i;
    assign last_out = (state_q != StIdle) && out_hs && (out_rem_q == 16'd1);
    // Keystream with no seed outstanding is stale and never enters the buffer.
    assign ks_push  = aes_keystream_valid_i && (outst_q != '0) && !fifo_full;

    keystream_fifo #(
        .Width (DW),
        .Depth (FIFODepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ks_push),
        .din_i   (aes_keystream_i),
        .pop_i   (in_hs),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        rem_d       = rem_q;
        out_rem_d   = out_rem_q;
        zero_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (job_valid_i) begin
                    seed_d    = job_iv_i;
                    rem_d     = job_count_i;
                    out_rem_d = job_count_i;
                    if (job_count_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue) begin
                    seed_d = seed_q + SeedWidth'(1);
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = StDrain;
                end
                if (out_hs) out_rem_d = out_rem_q - 16'd1;
            end
            StDrain: begin
                if (out_hs) out_rem_d = out_rem_q - 16'd1;
                if (last_out) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({issue, in_hs})
            2'b10:   outst_d = outst_q + CntW'(1);
            2'b01:   outst_d = outst_q - CntW'(1);
            default: outst_d = outst_q;
        endcase
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        if (in_hs) begin
            dout_d   = data_in_i ^ fifo_head;
            dvalid_d = 1'b1;
        end else if (data_out_ready_i) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            seed_q      <= '0;
            rem_q       <= '0;
            out_rem_q   <= '0;
            outst_q     <= '0;
            zero_done_q <= 1'b0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            rem_q       <= rem_d;
            out_rem_q   <= out_rem_d;
            outst_q     <= outst_d;
            zero_done_q <= zero_done_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign job_ready_o      = (state_q == StIdle);
    assign job_done_o       = zero_done_q || last_out;
    assign aes_seed_o       = seed_q;
    assign aes_seed_valid_o = issue;
    assign data_out_o       = dout_q;
    assign data_out_valid_o = dvalid_q;

`ifdef AES_CTR_CHECK_EN
    localparam int StallLim = FIFODepth + AESLatency;
    localparam int StallW   = clog2(StallLim + 1);

    logic              error_q, error_d;
    logic [StallW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = '0;
        if (data_in_valid_i && !in_hs) begin
            stall_d = (stall_q == StallW'(StallLim)) ? stall_q : stall_q + StallW'(1);
        end
        error_d = error_q
                | (aes_keystream_valid_i && (fifo_full || outst_q == '0))
                | (stall_d == StallW'(StallLim));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_q <= 1'b0;
            stall_q <= '0;
        end else begin
            error_q <= error_d;
            stall_q <= stall_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Scoreboard bench for aes_ctr_stream with a behavioural 21-cycle AES pipe model.
module tb_aes_ctr_stream;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] job_iv;
    logic [15:0]  job_count;
    logic         job_valid;
    logic         job_ready_o, job_done_o;
    logic [127:0] aes_seed_o;
    logic         aes_seed_valid_o;
    logic [127:0] aes_ks;
    logic         aes_ks_valid;
    logic [127:0] data_in;
    logic         data_in_valid;
    logic         data_in_ready_o;
    logic [127:0] data_out_o;
    logic         data_out_valid_o;
    logic         data_out_ready;
    logic         error_o;

    logic         data_en, inject;
    int           n_checks = 0, n_fail = 0;
    int           cyc = 0, seed_seen = 0, base = 0;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;
    logic [127:0] seed_exp[$];
    exp_t         out_exp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_ctr_stream dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .job_iv_i              (job_iv),
        .job_count_i           (job_count),
        .job_valid_i           (job_valid),
        .job_ready_o           (job_ready_o),
        .job_done_o            (job_done_o),
        .aes_seed_o            (aes_seed_o),
        .aes_seed_valid_o      (aes_seed_valid_o),
        .aes_keystream_i       (aes_ks),
        .aes_keystream_valid_i (aes_ks_valid),
        .data_in_i             (data_in),
        .data_in_valid_i       (data_in_valid),
        .data_in_ready_o       (data_in_ready_o),
        .data_out_o            (data_out_o),
        .data_out_valid_o      (data_out_valid_o),
        .data_out_ready_i      (data_out_ready),
        .error_o               (error_o)
    );

    function automatic logic [127:0] ks(input logic [127:0] s);
        return {s[63:0], s[127:64]} ^ {4{32'h5A5A_C3C3}};
    endfunction

    function automatic logic [127:0] word(input int k);
        return {4{32'hD000_0000 + 32'(k)}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AES pipe model: fixed latency, shares the DUT reset.
    logic [127:0] pipe_s [21];
    logic [20:0]  pipe_v;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[19:0], aes_seed_valid_o};
            pipe_s[0] <= aes_seed_o;
            for (int i = 1; i < 21; i++) pipe_s[i] <= pipe_s[i-1];
        end
    end
    assign aes_ks       = ks(pipe_s[20]);
    assign aes_ks_valid = pipe_v[20] | inject;

    // Data source: word index advances on each accepted handshake.
    initial begin
        int  k;
        logic hs;
        k = 0;
        hs = 1'b0;
        data_in_valid = 1'b0;
        data_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k = 0;
                hs = 1'b0;
            end else if (hs) begin
                k++;
            end
            data_in_valid = data_en & rst_n;
            data_in = word(k);
            #1 hs = data_in_valid & data_in_ready_o & rst_n;
        end
    end

    // Monitors
    always @(negedge clk) begin
        #2;
        if (rst_n && aes_seed_valid_o) begin
            seed_seen++;
            if (seed_exp.size() == 0) chk("seed_unexpected", aes_seed_valid_o, 1'b0);
            else chk("seed", aes_seed_o, seed_exp.pop_front());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && data_out_valid_o && data_out_ready) begin
            if (out_exp.size() == 0) begin
                chk("dout_unexpected", data_out_valid_o, 1'b0);
            end else begin
                e = out_exp.pop_front();
                chk("dout", data_out_o, e.data);
                chk("done_with_last", job_done_o, e.last);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_job_ready"}, job_ready_o, 1'b1);
        chk({tag, "_job_done"}, job_done_o, 1'b0);
        chk({tag, "_seed_valid"}, aes_seed_valid_o, 1'b0);
        chk({tag, "_seed"}, aes_seed_o, '0);
        chk({tag, "_din_ready"}, data_in_ready_o, 1'b0);
        chk({tag, "_dout_valid"}, data_out_valid_o, 1'b0);
        chk({tag, "_dout"}, data_out_o, '0);
        chk({tag, "_error"}, error_o, 1'b0);
    endtask

    task automatic submit(input logic [127:0] iv, input logic [15:0] cnt);
        exp_t e;
        @(negedge clk);
        chk("job_ready", job_ready_o, 1'b1);
        job_iv = iv;
        job_count = cnt;
        job_valid = 1'b1;
        for (int i = 0; i < int'(cnt); i++) begin
            seed_exp.push_back(iv + 128'(i));
            e.data = word(base + i) ^ ks(iv + 128'(i));
            e.last = (i == int'(cnt) - 1);
            out_exp.push_back(e);
        end
        base += int'(cnt);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            #2;
            if (job_done_o) got = 1'b1;
        end
        chk(name, got, 1'b1);
    endtask

    initial begin
        int t0, t1, s0;
        rst_n = 1'b0;
        job_iv = '0;
        job_count = '0;
        job_valid = 1'b0;
        data_en = 1'b0;
        data_out_ready = 1'b1;
        inject = 1'b0;
        repeat (3) @(negedge clk);
        #2 check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Job 1: basic 4-block job, latency and first output.
        data_en = 1'b1;
        submit(128'h10, 16'd4);
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 50 && t0 < 0; i++) begin
            #2;
            if (aes_seed_valid_o) t0 = cyc;
            else @(negedge clk);
        end
        for (int i = 0; i < 60 && t1 < 0; i++) begin
            @(negedge clk);
            #2;
            if (data_out_valid_o) t1 = cyc;
        end
        chk("first_out_latency", 128'(t1 - t0), 128'd23);
        chk("first_out_value", data_out_o, word(0) ^ ks(128'h10));
        wait_done(100, "job1_done");
        data_en = 1'b0;

        // Job 2: seed wraps through zero.
        data_en = 1'b1;
        submit({{127{1'b1}}, 1'b0}, 16'd4);
        wait_done(100, "job2_done");
        data_en = 1'b0;

        // Job 3: zero-length job.
        s0 = seed_seen;
        submit(128'h99, 16'd0);
        #2 chk("zero_job_done", job_done_o, 1'b1);
        @(negedge clk);
        #2 chk("zero_job_done_pulse", job_done_o, 1'b0);
        repeat (5) @(negedge clk);
        #2 chk("zero_job_no_seeds", 128'(seed_seen - s0), 128'd0);

        // Job 4: credit limit with output blocked, then release.
        data_out_ready = 1'b0;
        s0 = seed_seen;
        submit(128'h1000, 16'd100);
        repeat (80) @(negedge clk);
        #2;
        chk("credit_seeds", 128'(seed_seen - s0), 128'd32);
        chk("credit_seed_valid", aes_seed_valid_o, 1'b0);
        data_out_ready = 1'b1;
        data_en = 1'b1;
        wait_done(600, "job4_done");
        chk("job4_error", error_o, 1'b0);
        data_en = 1'b0;

        // Job 5: reset at the 10th issue, then a short job.
        data_en = 1'b1;
        s0 = seed_seen;
        submit(128'h2000, 16'd40);
        for (int i = 0; i < 100 && (seed_seen - s0) < 9; i++) @(negedge clk);
        chk("midjob_reach_issue9", 128'(seed_seen - s0 >= 9), 128'd1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        data_en = 1'b0;
        #2;
        seed_exp.delete();
        out_exp.delete();
        base = 0;
        check_reset("midjob_reset");
        @(negedge clk);
        rst_n = 1'b1;
        data_en = 1'b1;
        submit(128'h55, 16'd3);
        wait_done(100, "post_reset_done");
        data_en = 1'b0;

`ifdef AES_CTR_CHECK_EN
        // Stray keystream while nothing is outstanding.
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #2 chk("error_set", error_o, 1'b1);
        repeat (5) @(negedge clk);
        #2 chk("error_held", error_o, 1'b1);
        rst_n = 1'b0;
        #2 chk("error_cleared", error_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("seed_queue_empty", 128'(seed_exp.size()), 128'd0);
        chk("out_queue_empty", 128'(out_exp.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
